// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 frame constants, receiver FSM states, default parameters, parity helper
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FILTER_LEN = 8;
  localparam int DEF_TIMEOUT_CYC = 50000;
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO (push/wdata in, rd_en pops, rdata head or 0, count/full/empty)
module byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic pop, wr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = rd_en & ~empty;
  assign wr = push & (~full | pop);
  assign rdata = empty ? '0 : mem[rptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      rptr <= rptr + AW'(pop);
      wptr <= wptr + AW'(wr);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (sync+filter pins, deframe, parity/stop check) feeding a FWFT byte FIFO (fifo_ready/rdata/count/rd_en, parity_err pulse, sticky overflow)
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  output logic                        fifo_ready,
  output logic [7:0]                  rdata,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        parity_err,
  output logic                        overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(DATA_BITS);
  logic [1:0] clk_sync, dat_sync;
  logic filt, filt_q, strobe, bit_in, timeout, frame_end, good, push, bad, full, empty;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic par_bit;
  state_t state, state_n;
  assign bit_in = dat_sync[1];
  assign strobe = filt_q & ~filt;
  assign timeout = tcnt == TW'(TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      filt <= 1'b1;
      filt_q <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q <= filt;
      fcnt <= (clk_sync[1] == filt || fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
      filt <= (clk_sync[1] != filt && fcnt == FW'(FILTER_LEN - 1)) ? clk_sync[1] : filt;
    end
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = timeout ? IDLE :
              !strobe ? state :
              state == IDLE ? (bit_in == START_BIT ? DATA : IDLE) :
              state == DATA ? (bitcnt == BW'(DATA_BITS - 1) ? PARITY : DATA) :
              state == PARITY ? STOP : IDLE;
  end
  always_comb begin
    frame_end = strobe & (state == STOP) & ~timeout;
    good = (bit_in == STOP_BIT) & odd_parity_ok(shreg, par_bit);
    push = frame_end & good;
    bad = frame_end & ~good;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitcnt <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      tcnt <= '0;
      parity_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tcnt <= (state == IDLE || strobe) ? '0 : tcnt + 1'b1;
      if (strobe) begin
        bitcnt <= state == DATA ? bitcnt + 1'b1 : '0;
        shreg <= state == DATA ? {bit_in, shreg[DATA_BITS-1:1]} : shreg;
        par_bit <= state == PARITY ? bit_in : par_bit;
      end
      parity_err <= bad;
      overflow <= overflow | (push & full & ~rd_en);
    end
  end
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata(shreg), .rd_en(rd_en),
    .rdata(rdata), .count(count), .full(full), .empty(empty)
  );
  assign fifo_ready = ~empty;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench driving PS/2 frames against a queue model of the receive FIFO
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int FLEN = 8;
  localparam int TOUT = 1000;
  localparam int H = 20;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, rd_en = 0;
  logic fifo_ready, parity_err, overflow;
  logic [7:0] rdata;
  logic [3:0] count;
  int checks = 0, errors = 0, exp_perr = 0, seen_perr = 0;
  bit exp_ovf = 0, rd_allow = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .fifo_ready(fifo_ready), .rdata(rdata), .count(count), .parity_err(parity_err), .overflow(overflow)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(logic [7:0] b, logic par, logic stp, int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    if (nbits == 11) begin
      if (stp && (^{b, par})) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1;
      end else exp_perr++;
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(H);
      ps2_clk = 0;
      cyc(H);
      ps2_clk = 1;
    end
    cyc(H);
    ps2_data = 1;
  endtask
  task automatic check_state(string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, 32'(count), n);
    chk({tag, "_ready"}, 32'(fifo_ready), n != 0);
    chk({tag, "_rdata"}, 32'(rdata), n != 0 ? 32'(exp_q[0]) : 0);
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_perr_count"}, seen_perr, exp_perr);
  endtask
  task automatic drain(string tag);
    int n;
    n = 0;
    rd_allow = 1;
    while ((exp_q.size() != 0 || fifo_ready) && n < 3000) begin
      cyc(1);
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < 3000), 1);
    rd_allow = 0;
    cyc(2);
  endtask
  initial begin
    logic pp;
    pp = 0;
    forever begin
      @(negedge clk);
      if (parity_err) begin
        seen_perr++;
        chk("parity_err_width", 32'(pp), 0);
      end
      pp = parity_err;
      if (fifo_ready && rd_allow && $urandom_range(0, 2) == 0) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(rdata), 32'hFFFF_FFFF);
        else chk("rdata_pop", 32'(rdata), 32'(exp_q.pop_front()));
        rd_en = 1;
      end else rd_en = 0;
    end
  end
  initial begin
    logic [7:0] b;
    logic p, s;
    cyc(3);
    rst_n = 1;
    cyc(2);
    check_state("reset");
    chk("reset_parity_err", 32'(parity_err), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    cyc(5);
    check_state("t1");
    drain("t1");
    check_state("t1_drained");
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    cyc(5);
    check_state("t2_bad");
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    check_state("t2_f0");
    drain("t2");
    for (int i = 1; i <= 9; i++) send_frame(8'(i), ~^(8'(i)), 1'b1, 11);
    check_state("t3_full");
    drain("t3");
    check_state("t3_drained");
    send_frame(8'h00, 1'b0, 1'b1, 4);
    cyc(TOUT + 10);
    check_state("t4_timeout");
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    check_state("t4_5a");
    drain("t4");
    ps2_clk = 0;
    cyc(3);
    ps2_clk = 1;
    cyc(20);
    check_state("t5_glitch");
    send_frame(8'h29, 1'b0, 1'b1, 11);
    check_state("t5_29");
    drain("t5");
    send_frame(8'hA5, 1'b0, 1'b1, 5);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    exp_ovf = 0;
    exp_q.delete();
    cyc(2);
    check_state("t6_rst");
    chk("t6_rst_parity_err", 32'(parity_err), 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    check_state("t6_5a");
    drain("t6");
    rd_allow = 1;
    repeat (20) begin
      b = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ^b : ~^b;
      s = $urandom_range(0, 9) != 0;
      send_frame(b, p, s, 11);
      cyc($urandom_range(0, 30));
    end
    drain("rand");
    check_state("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
